mole_round_ctrl: RTL and testbench

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

---
 rtl/whackamole_pkg.sv | 22 ++
 rtl/mole_round_ctrl_if.sv | 26 ++
 rtl/mole_lfsr.sv | 35 +++
 rtl/mole_round_ctrl.sv | 106 ++++++++++
 tb/tb_mole_round_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/whackamole_pkg.sv
// rtl/whackamole_pkg.sv - shared types, LFSR constants and widths for the mole round controller
package whackamole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam int          SCORE_W           = 8;
  localparam int          ROUND_W           = 8;

  // Galois step, shifting right; the mask folds in when the bit shifted out is 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// rtl/mole_round_ctrl_if.sv - game-side signal bundle for the mole round controller
interface mole_round_ctrl_if
  import whackamole_pkg::*;
#(
  parameter int NUM_HOLES = 4
);
  logic                 start;
  logic [NUM_HOLES-1:0] btn;
  logic                 timer_timeout;
  logic                 timer_load;
  logic [NUM_HOLES-1:0] mole;
  logic [SCORE_W-1:0]   score;
  logic [ROUND_W-1:0]   round_cnt;
  logic                 game_over;
  logic [15:0]          lfsr;

  modport master (
    output start, btn, timer_timeout,
    input  timer_load, mole, score, round_cnt, game_over, lfsr
  );

  modport slave (
    input  start, btn, timer_timeout,
    output timer_load, mole, score, round_cnt, game_over, lfsr
  );
endinterface

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running LFSR and hole picker that never repeats the previous hole
module mole_lfsr
  import whackamole_pkg::*;
#(
  parameter int          NUM_HOLES = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  localparam int         IDX_W     = $clog2(NUM_HOLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [15:0]      lfsr_o
);

  logic [15:0]      lfsr_q;
  logic [IDX_W-1:0] prev_q;
  logic [IDX_W-1:0] raw_idx;

  // NUM_HOLES is a power of two, so the +1 wraps modulo NUM_HOLES for free
  assign raw_idx = lfsr_q[IDX_W-1:0];
  assign idx_o   = (raw_idx == prev_q) ? raw_idx + IDX_W'(1) : raw_idx;
  assign lfsr_o  = lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      prev_q <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (take_i) prev_q <= idx_o;
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - round sequencer: arm timer, light a hole, score the press, dark gap
module mole_round_ctrl
  import whackamole_pkg::*;
#(
  parameter int          NUM_HOLES  = 4,
  parameter int          ROUNDS     = 10,
  parameter int          GAP_CYCLES = 3_000_000,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  mole_round_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_HOLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_e               state_q;
  logic [NUM_HOLES-1:0] mole_q;
  logic [SCORE_W-1:0]   score_q;
  logic [ROUND_W-1:0]   round_q;
  logic                 game_over_q;
  logic                 timer_load_q;
  logic [GAP_W-1:0]     gap_q;
  logic [IDX_W-1:0]     pick_idx;
  logic [15:0]          lfsr_state;
  logic                 hit;
  logic                 miss;

  mole_lfsr #(
    .NUM_HOLES (NUM_HOLES),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .take_i (state_q == ST_ARM),
    .idx_o  (pick_idx),
    .lfsr_o (lfsr_state)
  );

  // A matching press wins even when the timer expires in the same cycle
  always_comb begin
    hit  = (bus.btn == mole_q);
    miss = (|bus.btn) || bus.timer_timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mole_q       <= '0;
      score_q      <= '0;
      round_q      <= '0;
      game_over_q  <= 1'b0;
      timer_load_q <= 1'b0;
      gap_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            score_q      <= '0;
            round_q      <= '0;
            game_over_q  <= 1'b0;
            timer_load_q <= 1'b1;
            state_q      <= ST_ARM;
          end
        end
        ST_ARM: begin
          timer_load_q <= 1'b0;
          mole_q       <= NUM_HOLES'(1) << pick_idx;
          state_q      <= ST_PLAY;
        end
        ST_PLAY: begin
          if (hit || miss) begin
            if (hit && score_q != {SCORE_W{1'b1}}) score_q <= score_q + SCORE_W'(1);
            mole_q  <= '0;
            round_q <= round_q + ROUND_W'(1);
            gap_q   <= GAP_W'(GAP_CYCLES - 1);
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            if (round_q == ROUND_W'(ROUNDS)) begin
              game_over_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              timer_load_q <= 1'b1;
              state_q      <= ST_ARM;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mole       = mole_q;
  assign bus.score      = score_q;
  assign bus.round_cnt  = round_q;
  assign bus.game_over  = game_over_q;
  assign bus.timer_load = timer_load_q;
  assign bus.lfsr       = lfsr_state;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - randomized and directed bench against an output-level game model
module tb_mole_round_ctrl;

  localparam int          N    = 4;
  localparam int          R    = 3;
  localparam int          G    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mole_round_ctrl_if #(.NUM_HOLES(N)) bus ();

  mole_round_ctrl #(
    .NUM_HOLES  (N),
    .ROUNDS     (R),
    .GAP_CYCLES (G),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state is only what the outside world sees: timer_load marks arming,
  // a lit mole marks play, a running gap count marks the dark gap.
  logic [15:0]  m_lfsr;
  int           m_prev;
  logic [N-1:0] m_mole;
  int           m_score;
  int           m_rounds;
  logic         m_over;
  logic         m_tl;
  int           m_gap;
  int           tl_pulses;
  int           moles_shown;
  logic [N-1:0] last_shown;
  logic [N-1:0] prev_obs;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic [15:0] n;
    n = v / 2;
    if (v % 2 == 1) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [N-1:0] b, input logic to);
    int idx;
    if (r) begin
      m_lfsr = SEED; m_prev = 0; m_mole = '0; m_score = 0; m_rounds = 0;
      m_over = 1'b0; m_tl = 1'b0; m_gap = 0;
      return;
    end
    if (m_tl) begin
      idx = int'(m_lfsr % N);
      if (idx == m_prev) idx = (idx + 1) % N;
      m_prev = idx;
      m_mole = '0;
      m_mole[idx] = 1'b1;
      m_tl = 1'b0;
    end else if (m_mole != '0) begin
      if (b != '0 || to) begin
        if (b == m_mole && m_score < 255) m_score++;
        m_mole = '0;
        m_rounds++;
        m_gap = G;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        if (m_rounds == R) m_over = 1'b1;
        else m_tl = 1'b1;
      end
    end else if (s) begin
      m_score = 0; m_rounds = 0; m_over = 1'b0; m_tl = 1'b1;
    end
    m_lfsr = ref_lfsr(m_lfsr);
  endtask

  task automatic cycle(input logic r, input logic s, input logic [N-1:0] b, input logic to);
    @(negedge clk);
    rst = r; bus.start = s; bus.btn = b; bus.timer_timeout = to;
    @(posedge clk);
    model_step(r, s, b, to);
    #1;
    check("mole", 32'(bus.mole), 32'(m_mole));
    check("score", 32'(bus.score), 32'(m_score));
    check("round_cnt", 32'(bus.round_cnt), 32'(m_rounds));
    check("game_over", 32'(bus.game_over), 32'(m_over));
    check("timer_load", 32'(bus.timer_load), 32'(m_tl));
    check("lfsr", 32'(bus.lfsr), 32'(m_lfsr));
    if (bus.timer_load) tl_pulses++;
    if (r) last_shown = 4'b0001;
    else if (bus.mole != '0 && prev_obs == '0) begin
      check("no_repeat", 32'(bus.mole != last_shown), 32'd1);
      last_shown = bus.mole;
      moles_shown++;
    end
    prev_obs = bus.mole;
  endtask

  function automatic logic [N-1:0] wrong_btn(input logic [N-1:0] m);
    return m | {m[N-2:0], m[N-1]};
  endfunction

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.btn = '0; bus.timer_timeout = 1'b0;
    last_shown = 4'b0001; prev_obs = '0; tl_pulses = 0; moles_shown = 0;
    model_step(1'b1, 1'b0, '0, 1'b0);

    cycle(1, 0, '0, 0);
    cycle(1, 1, 4'hF, 1);
    check("rst_lfsr_seed", 32'(bus.lfsr), 32'(SEED));
    check("rst_mole", 32'(bus.mole), 32'd0);
    check("rst_timer_load", 32'(bus.timer_load), 32'd0);

    // full game, every press hits
    tl_pulses = 0;
    cycle(0, 1, '0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, m_mole, 0);
    check("game_tl_pulses", 32'(tl_pulses), 32'd3);
    check("game_score", 32'(bus.score), 32'd3);
    check("game_rounds", 32'(bus.round_cnt), 32'd3);
    check("game_over_set", 32'(bus.game_over), 32'd1);

    // start from DONE, start ignored in PLAY, timeout miss
    cycle(0, 1, '0, 0);
    check("done_start_tl", 32'(bus.timer_load), 32'd1);
    check("done_start_score", 32'(bus.score), 32'd0);
    check("done_start_rounds", 32'(bus.round_cnt), 32'd0);
    cycle(0, 0, '0, 0);
    cycle(0, 1, '0, 0);
    check("play_start_ignored", 32'(bus.mole != '0), 32'd1);
    cycle(0, 0, '0, 1);
    check("timeout_mole_clear", 32'(bus.mole), 32'd0);
    check("timeout_score", 32'(bus.score), 32'd0);
    check("timeout_round", 32'(bus.round_cnt), 32'd1);
    cycle(0, 0, 4'hF, 0);
    cycle(0, 0, 4'h5, 1);
    check("gap_btn_ignored", 32'(bus.score), 32'd0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    cycle(0, 0, m_mole, 1);
    check("hit_beats_timeout", 32'(bus.score), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0);
    cycle(0, 0, wrong_btn(m_mole), 0);
    check("wrong_btn_score", 32'(bus.score), 32'd1);
    check("wrong_btn_round", 32'(bus.round_cnt), 32'd3);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0);
    check("game2_over", 32'(bus.game_over), 32'd1);

    // reset mid-PLAY, then 21 rounds of picks against the model
    cycle(0, 1, '0, 0);
    cycle(0, 0, '0, 0);
    cycle(1, 1, m_mole, 1);
    check("midplay_rst_mole", 32'(bus.mole), 32'd0);
    check("midplay_rst_lfsr", 32'(bus.lfsr), 32'(SEED));
    check("midplay_rst_score", 32'(bus.score), 32'd0);
    moles_shown = 0;
    for (int g = 0; g < 7; g++) begin
      cycle(0, 1, '0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 0, m_mole, 0);
    end
    check("pick_rounds", 32'(moles_shown), 32'd21);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic         r, s, to;
      logic [N-1:0] b;
      int           sel;
      r   = ($urandom % 200) == 0;
      s   = ($urandom % 8) == 0;
      to  = ($urandom % 6) == 0;
      sel = $urandom % 4;
      b   = (sel == 0) ? m_mole : (sel == 1) ? N'($urandom) : '0;
      cycle(r, s, b, to);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
